// File: rtl/pll_clock_divider.sv
// Programmable integer clock divider for the PLL phase-0 clock.
// Ratio changes and enable/disable take effect only at output period boundaries.
module pll_clock_divider #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_update,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 div_ack,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] div_cur
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                 en_s1_q, en_s_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 clk_out_q, clk_out_d;
  logic                 tick_q, tick_d;
  logic                 div_ack_q, div_ack_d;
  logic                 running_q, running_d;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] high_len;
  logic                 boundary;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_cur_d    = div_cur_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    div_ack_d    = 1'b0;

    div_clamped = (div_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_in;
    boundary    = (cnt_q == (div_cur_q - DIV_WIDTH'(1)));

    if (div_update) begin
      pend_div_d   = div_clamped;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A strobe in this cycle supersedes the older pending value, so hold off.
        if (pend_valid_q && !div_update) begin
          div_cur_d    = pend_div_q;
          pend_valid_d = 1'b0;
          div_ack_d    = 1'b1;
        end
        if (en_s_q) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (boundary) begin
          cnt_d = '0;
          if (pend_valid_d) begin
            div_cur_d    = pend_div_d;
            pend_valid_d = 1'b0;
            div_ack_d    = 1'b1;
          end
          state_d = en_s_q ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + DIV_WIDTH'(1);
          state_d = en_s_q ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with cnt_q.
    high_len  = div_cur_d - (div_cur_d >> 1);
    running_d = (state_d != IDLE);
    tick_d    = running_d && (cnt_d == '0);
    clk_out_d = running_d && (cnt_d < high_len);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      en_s1_q      <= 1'b0;
      en_s_q       <= 1'b0;
      cnt_q        <= '0;
      div_cur_q    <= DIV_WIDTH'(RESET_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      div_ack_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_s1_q      <= enable;
      en_s_q       <= en_s1_q;
      cnt_q        <= cnt_d;
      div_cur_q    <= div_cur_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      div_ack_q    <= div_ack_d;
      running_q    <= running_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_ack = div_ack_q;
  assign running = running_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_pll_clock_divider.sv
// Scoreboarded bench for pll_clock_divider: a period-level model predicts each
// output period; a negedge monitor checks the DUT's periods against those predictions.
module tb_pll_clock_divider;

  localparam int DW        = 8;
  localparam int RESET_DIV = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] div_in;
  logic          div_update;
  logic          clk_out, tick, div_ack, running;
  logic [DW-1:0] div_cur;

  pll_clock_divider #(.DIV_WIDTH(DW), .RESET_DIV(RESET_DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .div_in     (div_in),
    .div_update (div_update),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_ack    (div_ack),
    .running    (running),
    .div_cur    (div_cur)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  typedef struct {
    int ratio;
    bit ack;
  } period_t;

  period_t period_q[$];
  int      idle_ack_q[$];

  // Model: a period, once started, always runs to completion; whether another
  // follows depends only on the synchronized enable at its last cycle.
  bit m_en1, m_en2, m_active, exp_reset, mon_go;
  int m_left, m_ratio, m_pend;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_edge(input bit en, input bit upd, input int din, input bit rst);
    bit ens, ack, start;
    int eff;
    mon_go = 1'b1;
    if (rst) begin
      m_en1 = 0; m_en2 = 0; m_active = 0; m_left = 0;
      m_ratio = RESET_DIV; m_pend = 0;
      period_q.delete();
      idle_ack_q.delete();
      exp_reset = 1'b1;
      return;
    end
    ens = m_en2; ack = 0; start = 0;
    if (m_active && m_left > 1) begin
      m_left--;
      if (upd) m_pend = clampv(din);
    end else if (m_active) begin
      eff = upd ? clampv(din) : m_pend;
      if (eff != 0) begin m_ratio = eff; m_pend = 0; ack = 1; end
      m_active = 0;
      start = ens;
    end else begin
      if (upd) m_pend = clampv(din);
      else if (m_pend != 0) begin m_ratio = m_pend; m_pend = 0; ack = 1; end
      start = ens;
    end
    if (start) begin
      m_active = 1;
      m_left   = m_ratio;
      period_q.push_back('{ratio: m_ratio, ack: ack});
    end else if (ack) begin
      idle_ack_q.push_back(m_ratio);
    end
    m_en2 = m_en1;
    m_en1 = en;
  endtask

  bit en_lvl;

  task automatic step(input bit upd, input int din, input bit rst);
    @(negedge clock);
    enable     = en_lvl;
    div_update = upd;
    div_in     = DW'(din);
    reset      = rst;
    @(posedge clock);
    model_edge(en_lvl, upd, din, rst);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // Monitor
  bit      mon_in;
  int      mon_idx;
  period_t cur;

  always @(negedge clock) begin
    if (mon_go) begin
      if (exp_reset) begin
        exp_reset = 1'b0;
        mon_in    = 1'b0;
        chk("reset_clk_out", clk_out, 0);
        chk("reset_tick", tick, 0);
        chk("reset_div_ack", div_ack, 0);
        chk("reset_running", running, 0);
        chk("reset_div_cur", div_cur, RESET_DIV);
      end else begin
        if (tick) begin
          if (mon_in) chk("period_len", mon_idx, cur.ratio);
          chk("tick_expected", int'(period_q.size() > 0), 1);
          if (period_q.size() > 0) begin
            cur     = period_q.pop_front();
            mon_in  = 1'b1;
            mon_idx = 1;
            chk("tick_div_ack", div_ack, int'(cur.ack));
            chk("tick_div_cur", div_cur, cur.ratio);
            chk("tick_clk_out", clk_out, 1);
            chk("tick_running", running, 1);
          end else begin
            mon_in = 1'b0;
          end
        end else begin
          if (period_q.size() > 0) begin
            chk("tick_missing", tick, 1);
            void'(period_q.pop_front());
          end
          if (mon_in) begin
            if (mon_idx < cur.ratio) begin
              chk("clk_out_phase", clk_out, int'(mon_idx < (cur.ratio - cur.ratio / 2)));
              chk("running_mid", running, 1);
              chk("ack_mid", div_ack, 0);
              chk("div_cur_mid", div_cur, cur.ratio);
              mon_idx++;
            end else begin
              chk("stop_running", running, 0);
              chk("stop_clk_out", clk_out, 0);
              mon_in = 1'b0;
            end
          end else begin
            chk("idle_running", running, 0);
            chk("idle_clk_out", clk_out, 0);
          end
          if (!mon_in) begin
            if (div_ack) begin
              chk("idle_ack_expected", int'(idle_ack_q.size() > 0), 1);
              if (idle_ack_q.size() > 0) chk("idle_ack_div_cur", div_cur, idle_ack_q.pop_front());
            end else if (idle_ack_q.size() > 0) begin
              chk("idle_ack_missing", div_ack, 1);
              void'(idle_ack_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int k;
    reset = 1'b1; enable = 1'b0; div_in = '0; div_update = 1'b0;
    en_lvl = 1'b0;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    idle_cycles(2);

    // Enable at ratio 4: first rise on the third edge
    en_lvl = 1'b1;
    first  = 0;
    for (int i = 1; i <= 6 && first == 0; i++) begin
      step(1'b0, 0, 1'b0);
      #1;
      if (tick) first = i;
    end
    chk("first_rise_edge", first, 3);
    idle_cycles(12);

    // Odd ratio mid-period
    step(1'b1, 5, 1'b0);
    idle_cycles(16);

    // Clamp 0 -> 2
    step(1'b1, 0, 1'b0);
    idle_cycles(10);

    // 7 then 9 inside one period: only 9, one ack
    for (k = 0; k < 32 && !(m_active && m_left == m_ratio); k++) step(1'b0, 0, 1'b0);
    chk("reach_period_start", int'(m_active && m_left == m_ratio), 1);
    step(1'b1, 7, 1'b0);
    step(1'b1, 9, 1'b0);
    idle_cycles(25);

    // Update on the boundary cycle itself
    for (k = 0; k < 32 && !(m_active && m_left == 1); k++) step(1'b0, 0, 1'b0);
    chk("reach_boundary", int'(m_active && m_left == 1), 1);
    step(1'b1, 3, 1'b0);
    idle_cycles(10);

    // Disable at cnt=1 of N=6, then re-enable
    step(1'b1, 6, 1'b0);
    for (k = 0; k < 40 && !(m_ratio == 6 && m_left == 5); k++) step(1'b0, 0, 1'b0);
    chk("reach_n6_cnt1", int'(m_ratio == 6 && m_left == 5), 1);
    en_lvl = 1'b0;
    idle_cycles(15);
    en_lvl = 1'b1;
    idle_cycles(15);

    // Reset at cnt=2 of N=8 with an update pending
    step(1'b1, 8, 1'b0);
    for (k = 0; k < 40 && !(m_ratio == 8 && m_left == 7); k++) step(1'b0, 0, 1'b0);
    chk("reach_n8_cnt1", int'(m_ratio == 8 && m_left == 7), 1);
    step(1'b1, 5, 1'b0);
    step(1'b0, 0, 1'b1);
    idle_cycles(20);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      int din;
      bit upd, rst;
      if ($urandom_range(0, 39) == 0) en_lvl = ~en_lvl;
      upd = ($urandom_range(0, 9) == 0);
      din = $urandom_range(0, 15);
      if (din >= 14) din = $urandom_range(16, 40);
      rst = ($urandom_range(0, 399) == 0);
      step(upd, din, rst);
    end

    en_lvl = 1'b0;
    idle_cycles(60);
    chk("period_q_drained", period_q.size(), 0);
    chk("idle_ack_q_drained", idle_ack_q.size(), 0);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
